// File: rtl/button_debouncer_if.sv
// Pin-side bundle of the button debouncer: raw button level in,
// debounced level and rejected-transition count out.
interface button_debouncer_if;
   logic       i_data;
   logic       o_level;
   logic [7:0] o_bounce_cnt;

   modport master (
      output i_data,
      input  o_level,
      input  o_bounce_cnt
   );

   modport slave (
      input  i_data,
      output o_level,
      output o_bounce_cnt
   );
endinterface

// File: rtl/button_debouncer.sv
// Single-channel push-button debouncer: two-flop synchronizer feeding a
// four-state candidate FSM with a stability counter and bounce statistics.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_WIDTH       = 19
) (
   input  logic               i_clk,
   input  logic               i_rst,
   button_debouncer_if.slave  bus
);

   typedef enum logic [1:0] {
      S_LOW  = 2'd0,
      S_RISE = 2'd1,
      S_HIGH = 2'd2,
      S_FALL = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic                 sync0_r;
   logic                 sync1_r;
   state_t               state_r;
   state_t               state_nxt_s;
   logic [CNT_WIDTH-1:0] cnt_r;
   logic [CNT_WIDTH-1:0] cnt_nxt_s;
   logic                 bounce_inc_s;
   logic [7:0]           bounce_r;
   logic                 level_r;
   logic                 level_nxt_s;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : (v + 8'd1);
   endfunction

   // Bring the asynchronous pin into the clock domain.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync0_r <= 1'b0;
         sync1_r <= 1'b0;
      end else begin
         sync0_r <= bus.i_data;
         sync1_r <= sync0_r;
      end
   end

   // Next-state, counter and bounce decisions; a reversion wins over the terminal count.
   always_comb begin
      state_nxt_s  = state_r;
      cnt_nxt_s    = cnt_r;
      bounce_inc_s = 1'b0;
      case (state_r)
         S_LOW: begin
            if (sync1_r) begin
               state_nxt_s = S_RISE;
               cnt_nxt_s   = {CNT_WIDTH{1'b0}};
            end else begin
               state_nxt_s = S_LOW;
            end
         end
         S_RISE: begin
            if (!sync1_r) begin
               state_nxt_s  = S_LOW;
               bounce_inc_s = 1'b1;
            end else if (cnt_r == CNT_LAST) begin
               state_nxt_s = S_HIGH;
            end else begin
               cnt_nxt_s = cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
         end
         S_HIGH: begin
            if (!sync1_r) begin
               state_nxt_s = S_FALL;
               cnt_nxt_s   = {CNT_WIDTH{1'b0}};
            end else begin
               state_nxt_s = S_HIGH;
            end
         end
         S_FALL: begin
            if (sync1_r) begin
               state_nxt_s  = S_HIGH;
               bounce_inc_s = 1'b1;
            end else if (cnt_r == CNT_LAST) begin
               state_nxt_s = S_LOW;
            end else begin
               cnt_nxt_s = cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_nxt_s = S_LOW;
            cnt_nxt_s   = {CNT_WIDTH{1'b0}};
         end
      endcase
      level_nxt_s = (state_nxt_s == S_HIGH) || (state_nxt_s == S_FALL);
   end

   // State, counter and registered outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_r  <= S_LOW;
         cnt_r    <= {CNT_WIDTH{1'b0}};
         bounce_r <= 8'd0;
         level_r  <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         cnt_r    <= cnt_nxt_s;
         level_r  <= level_nxt_s;
         if (bounce_inc_s) begin
            bounce_r <= sat_inc8(bounce_r);
         end else begin
            bounce_r <= bounce_r;
         end
      end
   end

   assign bus.o_level      = level_r;
   assign bus.o_bounce_cnt = bounce_r;

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Single-channel debouncer for mechanical push-buttons and switches. It synchronizes the raw asynchronous pin into the `i_clk` domain and rejects bounce. It emits a clean level only after the input has held a new value for `DEBOUNCE_CYCLES` consecutive clocks. It sits directly upstream of `level_to_pulse`: `o_level` drives that block's `i_data`, which turns each clean press into a one-cycle pulse for the motion-control logic.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a change (10 ms at 50 MHz). Legal range is 1..2^`CNT_WIDTH`.
- `CNT_WIDTH`, default 19: width of the stability counter.
- `i_clk`  input  1  system clock; all logic is on its rising edge.
- `i_rst`  input  1  reset, asynchronous, active-high.
- `i_data`  input  1  raw button level, asynchronous to `i_clk`, may bounce.
- `o_level`  output  1  debounced level; feeds `level_to_pulse.i_data`.
- `o_bounce_cnt`  output  8  saturating count of rejected candidate transitions, for diagnostics.

## Operation
- **Synchronizer.** Two flops in series, `sync0 <= i_data` and `sync1 <= sync0`. `s` = `sync1`. Nothing else samples `i_data`.
- **FSM states.**
  - `S_LOW`: `o_level` = 0.
  - `S_RISE`: candidate high; `o_level` = 0.
  - `S_HIGH`: `o_level` = 1.
  - `S_FALL`: candidate low; `o_level` = 1.
- **`o_level`** is a decode of the state register only (no combinational path from `i_data`). It is 1 exactly in `S_HIGH` and `S_FALL`.
- **Counter `cnt`** (`CNT_WIDTH` bits):
  - Cleared on every entry to `S_RISE` or `S_FALL`.
  - Increments by 1 each cycle the FSM stays in a candidate state.
  - Never wraps, because the FSM exits a candidate state at `DEBOUNCE_CYCLES`-1.
- **Transitions** (evaluated every clock):
  - `S_LOW`: `s`=1 → `S_RISE`, `cnt` <= 0. Otherwise stay.
  - `S_RISE`: `s`=0 → `S_LOW` and increment `o_bounce_cnt`. Else if `cnt` == `DEBOUNCE_CYCLES`-1 → `S_HIGH`. Else `cnt` <= `cnt`+1.
  - `S_HIGH`: `s`=0 → `S_FALL`, `cnt` <= 0. Otherwise stay.
  - `S_FALL`: `s`=1 → `S_HIGH` and increment `o_bounce_cnt`. Else if `cnt` == `DEBOUNCE_CYCLES`-1 → `S_LOW`. Else `cnt` <= `cnt`+1.
- **`o_bounce_cnt`** saturates at 255 and holds there. It is cleared only by reset.
- **Unused encodings.** Any unused state encoding → `S_LOW` on the next clock.
- **Reset.** While `i_rst`=1, regardless of clock:
  - `sync0` = `sync1` = 0, state = `S_LOW`, `cnt` = 0, `o_bounce_cnt` = 0, `o_level` = 0.
  - Asserting reset mid-candidate aborts it with no `o_bounce_cnt` increment.
  - If `i_data` is 1 when reset releases, the block takes the normal rising path.

## Timing
- **Edge numbering.** Edge 0 is the first rising edge at which `sync0` captures the new `i_data` value.
- **Accept latency.** With `i_data` held stable from edge 0, `o_level` changes after edge 2+`DEBOUNCE_CYCLES`. That is `DEBOUNCE_CYCLES`+2 cycles, the same for rise and fall.
- **Cycle breakdown:**
  - Edge 1: `sync1` updates.
  - Edge 2: FSM enters the candidate state with `cnt`=0.
  - Edge 2+k: FSM tests `cnt`=k-1.
  - `DEBOUNCE_CYCLES`=1 gives 3-cycle latency.
- **Minimum accepted pulse.** A level held for ≥ `DEBOUNCE_CYCLES`+1 synchronized cycles is accepted. One that reverts sooner is rejected: `o_level` never moves and `o_bounce_cnt` increments once per reversion.
- **Reverted candidate.** A reversion on the same clock that `cnt` reaches `DEBOUNCE_CYCLES`-1 is a rejection, because the `s` test has priority.
- **Output shape.** `o_level` is glitch-free and changes at most once per `DEBOUNCE_CYCLES`+1 cycles. Downstream `level_to_pulse` sees at most one rising edge per accepted press.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and a 20 ns clock.

1. Reset with `i_data`=0, then release. Outputs hold 0: `o_level`=0, `o_bounce_cnt`=0, state `S_LOW`.
2. Clean press: `i_data` 0→1 held. `o_level` rises exactly 6 cycles after the capturing edge. Release held low: `o_level` falls 6 cycles later. `o_bounce_cnt`=0.
3. Bounce burst 1,0,1,0,1 (2-cycle segments), then steady 1. Each 0 after a 1 aborts `S_RISE`; `o_bounce_cnt`=2. `o_level` rises 6 cycles after the final steady 1 is captured.
4. 4-cycle high glitch while low (reverts with `cnt`=3 tested). `o_level` stays 0, `o_bounce_cnt` +1. A 5-cycle high is accepted.
5. `i_rst` pulsed mid-`S_RISE` (`cnt`=2) with `i_data` still 1. All outputs 0 immediately. After release, `o_level`=1 six cycles after the first post-reset edge.
6. 300 rejected glitches. `o_bounce_cnt` saturates at 255, then holds. Chain with `level_to_pulse`: one clean press yields exactly one `o_pulse`.
